// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared states, default width and counter sizing for the isqrt engine
package isqrt_pkg;

    localparam int ISQRT_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration counter width, clog2(W/2), kept at least one bit wide.
    function automatic int cnt_w(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one combinational restoring square-root iteration
module isqrt_step #(
    parameter int W = 32
) (
    input  logic [W/2:0]   i_rem,
    input  logic [1:0]     i_rad_top,
    input  logic [W/2-1:0] i_root,
    output logic [W/2:0]   o_rem,
    output logic           o_bit
);

    localparam int RW = W / 2;

    logic [RW+2:0] w_t;
    logic [RW+1:0] w_q;
    logic          w_ge;

    assign w_t  = {i_rem, i_rad_top};
    assign w_q  = {i_root, 2'b01};
    assign w_ge = (w_t >= {1'b0, w_q});

    // The new remainder is bounded by 2*root, so the low bits of the difference suffice.
    assign o_bit = w_ge;
    assign o_rem = w_ge ? (w_t[RW:0] - w_q[RW:0]) : w_t[RW:0];

endmodule

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential integer square root, one root bit per cycle
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int W = ISQRT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W/2-1:0] out_root,
    output logic [W/2:0]   out_rem,
    output logic           busy
);

    localparam int RW = W / 2;
    localparam int CW = cnt_w(W);

    logic [1:0]    r_state;
    logic [W-1:0]  r_rad;
    logic [RW:0]   r_rem;
    logic [RW-1:0] r_root;
    logic [CW-1:0] r_count;

    logic [RW:0]   w_rem_next;
    logic          w_bit;

    isqrt_step #(
        .W(W)
    ) u_step (
        .i_rem    (r_rem),
        .i_rad_top(r_rad[W-1:W-2]),
        .i_root   (r_root),
        .o_rem    (w_rem_next),
        .o_bit    (w_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rad   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_rad   <= in_data;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_count <= CW'(RW - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_rem  <= w_rem_next;
                    r_root <= {r_root[RW-2:0], w_bit};
                    r_rad  <= {r_rad[W-3:0], 2'b00};
                    // The last step still runs on the cycle that count reads zero.
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = (r_state == ST_DONE);
    assign out_root  = r_root;
    assign out_rem   = r_rem;

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
- Sequential integer square-root engine; the inverse of the existing squaring datapath.
- Accepts a W-bit unsigned radicand over a valid/ready handshake.
- Produces floor(sqrt(x)) and the remainder x - root², one root bit per cycle, restoring digit-by-digit method.
- Instantiated beside the squarer so that sqrt(a*a) == a can be checked on-chip.

Parameters:
- W, 32, radicand width in bits; must be even and at least 4. Root width is W/2; remainder width is W/2+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  radicand offered.
- in_ready  output  1  engine can accept a radicand.
- in_data  input  W  unsigned radicand x.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_root  output  W/2  floor(sqrt(x)).
- out_rem  output  W/2+1  x - out_root².
- busy  output  1  high while iterating (state BUSY).

Behaviour:
- Reset: rst_n low forces state IDLE immediately, regardless of clock. Resulting outputs: in_ready=1, out_valid=0, busy=0, out_root=0, out_rem=0. Internal rad, rem, root and count clear to 0.
- Reset mid-operation: the computation in flight is discarded and no result is emitted.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: capture rad<=in_data, rem<=0, root<=0, count<=W/2-1, then go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle runs one step, defined as:
    - t = {rem, rad[W-1:W-2]} (W/2+3 bits).
    - q = {root, 2'b01}.
    - If t >= q: rem<=t-q and root<={root[W/2-2:0],1}.
    - Otherwise: rem<=t and root<={root[W/2-2:0],0}.
    - rad<=rad<<2.
  - When count==0 the step still executes and the state goes to DONE. Otherwise count decrements.
- DONE:
  - out_valid=1; out_root and out_rem come directly from the root and rem registers.
  - Outputs stay stable while out_ready=0.
  - On out_ready=1, go to IDLE on the next edge.
- Latency: the input handshake is at edge E; out_valid rises after edge E+W/2 (W/2 BUSY cycles). With out_ready held at 1, a new input can be accepted W/2+2 cycles after the previous one.
- in_ready is low in BUSY and DONE. A same-cycle output and input handshake is not supported; in_valid in those states is ignored and must be held by the producer.
- Width rules:
  - rem never exceeds 2*root, so it fits in W/2+1 bits.
  - The compare and subtract use W/2+3 bits internally with no truncation.
  - Invariant in DONE: root*root+rem == x, and rem <= 2*root.
- Boundary values:
  - x=0 gives root 0, rem 0.
  - x=2^W-1 gives root 2^(W/2)-1, rem 2^(W/2+1)-2 (all but LSB set).
  - A perfect square gives rem=0.
- in_data is sampled only at the accept edge; later changes have no effect.

Decomposition:
- Package isqrt_pkg holds:
  - the state enumeration {IDLE, BUSY, DONE} (2-bit encoding);
  - the default W;
  - a function or constant for the count width, clog2(W/2).
- One sub-module, isqrt_step: purely combinational single iteration.
  - Inputs: rem, rad top 2 bits, root.
  - Outputs: next rem, next root bit.
  - Allows unrolling later without touching the control FSM.
- The FSM, counter and handshakes stay in isqrt_seq.

Test Plan:
- Perfect square and zero (W=32): x=0x00010000 -> root 0x0100, rem 0x00000. x=0 -> root 0, rem 0. In both cases out_valid rises exactly 16 cycles after the accept edge.
- Non-square and maximum: x=17 -> root 4, rem 1. x=0xFFFFFFFF -> root 0xFFFF, rem 0x1FFFE.
- Backpressure: x=1000000 gives root 1000, rem 0. Hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable and in_ready stays 0. The result is released on the cycle out_ready=1 and in_ready=1 on the following cycle.
- Busy rejection: toggle in_valid with different in_data during BUSY. The result still matches the first accepted radicand, and no extra result appears.
- Async reset at step 7 of x=0xDEADBEEF: in_ready=1, busy=0 and out_valid=0 without a clock edge. A following x=144 -> root 12, rem 0.
- Random: 10k radicands with random in_valid/out_ready gaps. Every result satisfies root*root+rem==x and rem<=2*root. Also feed a*a from the squarer for a in 0..2^16-1 and check root==a, rem==0.
